uart_tx_arbiter: RTL and testbench



---
 rtl/uart_tx_arbiter.sv | 159 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Shares one UART TX character FIFO among NUM_REQ byte-stream requesters.
// Once a requester wins, its grant is held until it sends the byte marked
// req_last, so messages never interleave on the serial line. Packets are
// arbitrated round-robin. An idle watchdog takes the FIFO back from a
// requester that stops sending in the middle of a packet.
//
// Ports
//   clk            system clock, rising edge
//   rst_clk_tx_n   asynchronous active-low reset
//   req_valid      per-requester byte valid            [NUM_REQ]
//   req_data       per-requester byte, lane i = [8i+7:8i]
//   req_last       per-requester last-byte-of-packet   [NUM_REQ]
//   req_ready      per-requester byte accepted (comb)  [NUM_REQ]
//   tx_fifo_full   TX FIFO full flag
//   tx_fifo_din    byte to the TX FIFO (comb)
//   tx_fifo_wr_en  TX FIFO write strobe (comb)
//   grant_id       current or most recent grantee (registered)
//   busy           high while a packet owns the FIFO (comb)
//   pkt_abort      one-cycle pulse when the watchdog revokes a grant (registered)

module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned GRANT_W        = 2,
    parameter int unsigned TIMEOUT_CYCLES = 65535,
    parameter int unsigned TO_W           = 16
) (
    input  logic                   clk,
    input  logic                   rst_clk_tx_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic                   tx_fifo_full,
    output logic [7:0]             tx_fifo_din,
    output logic                   tx_fifo_wr_en,
    output logic [GRANT_W-1:0]     grant_id,
    output logic                   busy,
    output logic                   pkt_abort
);

    localparam int unsigned    BYTE_W  = 8;
    localparam logic           WD_EN   = (TIMEOUT_CYCLES != 0);
    // Counter value at which a still-idle grantee loses the grant.
    localparam logic [TO_W-1:0] WD_LAST =
        (TIMEOUT_CYCLES != 0) ? TO_W'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_XFER = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [GRANT_W-1:0]   grant_q, grant_d;
    logic [TO_W-1:0]      wd_q, wd_d;
    logic                 abort_q, abort_d;

    logic                 g_valid;
    logic                 g_last;
    logic [BYTE_W-1:0]    g_data;

    logic                 found;
    logic [GRANT_W-1:0]   pick;

    // Select the granted requester's lane.
    always_comb begin
        g_valid = 1'b0;
        g_last  = 1'b0;
        g_data  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_q == GRANT_W'(i)) begin
                g_valid = req_valid[i];
                g_last  = req_last[i];
                g_data  = req_data[BYTE_W*i +: BYTE_W];
            end
        end
    end

    // Round-robin pick: first valid requester after the last grantee.
    always_comb begin
        found = 1'b0;
        pick  = grant_q;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (!found && (i == ((32'(grant_q) + k) % NUM_REQ)) && req_valid[i]) begin
                    found = 1'b1;
                    pick  = GRANT_W'(i);
                end
            end
        end
    end

    // State, grant, watchdog and abort registers.
    always_ff @(posedge clk or negedge rst_clk_tx_n) begin
        if (!rst_clk_tx_n) begin
            state_q <= S_IDLE;
            grant_q <= GRANT_W'(NUM_REQ - 1);
            wd_q    <= '0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            wd_q    <= wd_d;
            abort_q <= abort_d;
        end
    end

    // Next state and pass-through datapath.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        wd_d          = wd_q;
        abort_d       = 1'b0;
        req_ready     = '0;
        tx_fifo_wr_en = 1'b0;
        busy          = 1'b0;
        tx_fifo_din   = g_data;

        case (state_q)
            S_IDLE: begin
                // Entering XFER starts the watchdog from zero.
                wd_d = '0;
                if (found) begin
                    grant_d = pick;
                    state_d = S_XFER;
                end
            end

            S_XFER: begin
                busy = 1'b1;
                if (g_valid && !tx_fifo_full) begin
                    req_ready     = NUM_REQ'(1) << grant_q;
                    tx_fifo_wr_en = 1'b1;
                    wd_d          = '0;
                    if (g_last) begin
                        state_d = S_IDLE;
                    end
                end else if (!g_valid && WD_EN) begin
                    // Only a silent grantee ages; a full FIFO never does.
                    if (wd_q == WD_LAST) begin
                        state_d = S_IDLE;
                        abort_d = 1'b1;
                        wd_d    = '0;
                    end else begin
                        wd_d = wd_q + TO_W'(1);
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign grant_id  = grant_q;
    assign pkt_abort = abort_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: single packet, round-robin order,
// FIFO backpressure, watchdog revoke, async reset mid-packet, and a new
// request arriving on another requester's last beat.

module tb_uart_tx_arbiter;

    localparam int unsigned NUM_REQ        = 4;
    localparam int unsigned GRANT_W        = 2;
    localparam int unsigned TIMEOUT_CYCLES = 8;
    localparam int unsigned TO_W           = 4;

    logic                 clk;
    logic                 rst_clk_tx_n;
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 tx_fifo_full;
    logic [7:0]           tx_fifo_din;
    logic                 tx_fifo_wr_en;
    logic [GRANT_W-1:0]   grant_id;
    logic                 busy;
    logic                 pkt_abort;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    uart_tx_arbiter #(
        .NUM_REQ        (NUM_REQ),
        .GRANT_W        (GRANT_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TO_W           (TO_W)
    ) dut (
        .clk           (clk),
        .rst_clk_tx_n  (rst_clk_tx_n),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_last      (req_last),
        .req_ready     (req_ready),
        .tx_fifo_full  (tx_fifo_full),
        .tx_fifo_din   (tx_fifo_din),
        .tx_fifo_wr_en (tx_fifo_wr_en),
        .grant_id      (grant_id),
        .busy          (busy),
        .pkt_abort     (pkt_abort)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [7:0] d, input logic l);
        req_valid[i]       = v;
        req_data[8*i +: 8] = d;
        req_last[i]        = l;
    endtask

    // Expect a beat from requester id carrying byte din.
    task automatic chk_beat(input string tag, input int id, input logic [7:0] din);
        chk({tag, "_wr"},    32'(tx_fifo_wr_en), 32'(1));
        chk({tag, "_din"},   32'(tx_fifo_din),   32'(din));
        chk({tag, "_ready"}, 32'(req_ready),     32'(1) << id);
        chk({tag, "_grant"}, 32'(grant_id),      32'(id));
        chk({tag, "_busy"},  32'(busy),          32'(1));
    endtask

    // Expect no transfer and not busy.
    task automatic chk_idle(input string tag);
        chk({tag, "_wr"},    32'(tx_fifo_wr_en), 32'(0));
        chk({tag, "_ready"}, 32'(req_ready),     32'(0));
        chk({tag, "_busy"},  32'(busy),          32'(0));
    endtask

    initial begin
        rst_clk_tx_n = 1'b0;
        req_valid    = '0;
        req_data     = '0;
        req_last     = '0;
        tx_fifo_full = 1'b0;

        // Reset values
        tick();
        tick();
        chk("rst_grant", 32'(grant_id), 32'(3));
        chk("rst_abort", 32'(pkt_abort), 32'(0));
        chk_idle("rst");
        rst_clk_tx_n = 1'b1;
        tick();

        // Single requester, 3-byte packet from requester 2
        set_req(2, 1'b1, 8'h41, 1'b0);
        #1 chk_idle("t1_arb");
        tick();
        #1 chk_beat("t1_b0", 2, 8'h41);
        tick();
        set_req(2, 1'b1, 8'h42, 1'b0);
        #1 chk_beat("t1_b1", 2, 8'h42);
        tick();
        set_req(2, 1'b1, 8'h43, 1'b1);
        #1 chk_beat("t1_b2", 2, 8'h43);
        tick();
        set_req(2, 1'b0, 8'h00, 1'b0);
        #1 chk_idle("t1_end");
        chk("t1_grant_kept", 32'(grant_id), 32'(2));
        tick();

        // Round-robin after a fresh reset: 0,1,2,3,0,1
        rst_clk_tx_n = 1'b0;
        #1 chk("rr_rst_grant", 32'(grant_id), 32'(3));
        tick();
        rst_clk_tx_n = 1'b1;
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, 8'(16 * i), 1'b0);
        for (int p = 0; p < 6; p++) begin
            int id;
            id = p % 4;
            #1 chk_idle($sformatf("rr%0d_gap", p));
            tick();
            #1 chk_beat($sformatf("rr%0d_b0", p), id, 8'(16 * id));
            tick();
            set_req(id, 1'b1, 8'(16 * id + 1), 1'b1);
            #1 chk_beat($sformatf("rr%0d_b1", p), id, 8'(16 * id + 1));
            tick();
            set_req(id, 1'b1, 8'(16 * id), 1'b0);
        end
        req_valid = '0;
        req_last  = '0;
        #1 chk_idle("rr_end");
        tick();

        // Backpressure: 5 full cycles in the middle of a packet from requester 1
        set_req(1, 1'b1, 8'hB0, 1'b0);
        #1 chk_idle("bp_arb");
        tick();
        #1 chk_beat("bp_b0", 1, 8'hB0);
        tick();
        set_req(1, 1'b1, 8'hB1, 1'b0);
        #1 chk_beat("bp_b1", 1, 8'hB1);
        tick();
        set_req(1, 1'b1, 8'hB2, 1'b0);
        tx_fifo_full = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("bp_stall%0d_wr", k),    32'(tx_fifo_wr_en), 32'(0));
            chk($sformatf("bp_stall%0d_ready", k), 32'(req_ready),     32'(0));
            chk($sformatf("bp_stall%0d_grant", k), 32'(grant_id),      32'(1));
            chk($sformatf("bp_stall%0d_busy", k),  32'(busy),          32'(1));
            chk($sformatf("bp_stall%0d_abort", k), 32'(pkt_abort),     32'(0));
            chk($sformatf("bp_stall%0d_din", k),   32'(tx_fifo_din),   32'(8'hB2));
            tick();
        end
        tx_fifo_full = 1'b0;
        #1 chk_beat("bp_b2", 1, 8'hB2);
        tick();
        set_req(1, 1'b1, 8'hB3, 1'b1);
        #1 chk_beat("bp_b3", 1, 8'hB3);
        tick();
        set_req(1, 1'b0, 8'h00, 1'b0);
        #1 chk_idle("bp_end");
        chk("bp_abort", 32'(pkt_abort), 32'(0));
        tick();

        // Watchdog: requester 0 goes silent after one byte, requester 3 waits
        set_req(0, 1'b1, 8'hC0, 1'b0);
        #1 chk_idle("wd_arb");
        tick();
        #1 chk_beat("wd_b0", 0, 8'hC0);
        tick();
        set_req(0, 1'b0, 8'h00, 1'b0);
        set_req(3, 1'b1, 8'hD0, 1'b1);
        for (int k = 0; k < 8; k++) begin
            #1;
            chk($sformatf("wd_hold%0d_busy", k),  32'(busy),          32'(1));
            chk($sformatf("wd_hold%0d_abort", k), 32'(pkt_abort),     32'(0));
            chk($sformatf("wd_hold%0d_wr", k),    32'(tx_fifo_wr_en), 32'(0));
            chk($sformatf("wd_hold%0d_ready", k), 32'(req_ready),     32'(0));
            tick();
        end
        #1 chk("wd_abort_pulse", 32'(pkt_abort), 32'(1));
        chk_idle("wd_revoked");
        tick();
        #1 chk("wd_abort_clear", 32'(pkt_abort), 32'(0));
        chk_beat("wd_next", 3, 8'hD0);
        tick();
        set_req(3, 1'b0, 8'h00, 1'b0);
        #1 chk_idle("wd_end");
        tick();

        // Async reset during a beat, then requester 0 wins first
        set_req(1, 1'b1, 8'hE0, 1'b0);
        #1 chk_idle("ar_arb");
        tick();
        #1 chk_beat("ar_b0", 1, 8'hE0);
        rst_clk_tx_n = 1'b0;
        #1 chk_idle("ar_rst_now");
        chk("ar_rst_grant", 32'(grant_id), 32'(3));
        set_req(0, 1'b1, 8'hF0, 1'b1);
        set_req(1, 1'b1, 8'hE1, 1'b0);
        set_req(2, 1'b1, 8'hA2, 1'b0);
        set_req(3, 1'b1, 8'hA3, 1'b0);
        tick();
        #1 chk_idle("ar_rst_hold");
        rst_clk_tx_n = 1'b1;
        #1 chk_idle("ar_release");
        tick();
        #1 chk_beat("ar_first", 0, 8'hF0);
        tick();
        req_valid = '0;
        req_last  = '0;
        #1 chk_idle("ar_end");
        tick();

        // Requester 2 requests on requester 1's last beat
        set_req(1, 1'b1, 8'h61, 1'b0);
        #1 chk_idle("sl_arb");
        tick();
        #1 chk_beat("sl_b0", 1, 8'h61);
        tick();
        set_req(1, 1'b1, 8'h62, 1'b1);
        set_req(2, 1'b1, 8'h71, 1'b1);
        #1 chk_beat("sl_last", 1, 8'h62);
        tick();
        set_req(1, 1'b1, 8'h63, 1'b1);
        #1 chk_idle("sl_gap");
        tick();
        #1 chk_beat("sl_r2", 2, 8'h71);
        tick();
        set_req(2, 1'b0, 8'h00, 1'b0);
        #1 chk_idle("sl_gap2");
        tick();
        #1 chk_beat("sl_r1_again", 1, 8'h63);
        tick();
        set_req(1, 1'b0, 8'h00, 1'b0);
        #1 chk_idle("sl_end");
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
